// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encodings and
// default frame parameters.
package uart_tx_scheduler_pkg;

    localparam int DEF_WORD_LENGTH  = 8;
    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_FRAME_BITS   = DEF_WORD_LENGTH + 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Start + data + parity + stop bits for a given word length.
    function automatic int frame_bits(input int word_length);
        return word_length + 3;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_priority_picker.sv
// Round-robin picker: rotates the request vector so the source after
// last_grant sits at bit 0, priority-encodes the lowest set bit, then
// rotates the index back.
module rr_priority_picker #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [IW-1:0]      winner,
    output logic               valid
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [IW:0]          shift;
    logic [IW:0]          rot_idx [NUM_REQ];
    logic [NUM_REQ-1:0]   rot_req;
    logic [IW-1:0]        pos;
    logic [IW:0]          sum;

    assign req_dbl = {req, req};
    assign shift   = (IW+1)'(last_grant) + (IW+1)'(1);

    // Doubling the vector turns the rotation into a plain indexed read.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign rot_idx[gi] = shift + (IW+1)'(gi);
            assign rot_req[gi] = req_dbl[rot_idx[gi]];
        end
    endgenerate

    // Lowest set bit of the rotated vector wins, mapped back to a source index.
    always_comb begin
        pos = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                pos = IW'(i);
            end
        end
        sum = shift + (IW+1)'(pos);
        if (sum >= (IW+1)'(NUM_REQ)) begin
            winner = IW'(sum - (IW+1)'(NUM_REQ));
        end else begin
            winner = IW'(sum);
        end
        valid = |req;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte sources. The UART has no
// busy flag, so each frame is timed locally for FRAME_CYCLES cycles
// (the LOAD cycle plus FRAME_CYCLES-1 WAIT cycles).
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int WORD_LENGTH  = DEF_WORD_LENGTH,
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FRAME_BITS   = WORD_LENGTH + 3,
    localparam int GW          = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*WORD_LENGTH-1:0] data_in,
    output logic [NUM_REQ-1:0]           ack,
    output logic [WORD_LENGTH-1:0]       DATATX,
    output logic                         Transmit,
    output logic                         busy,
    output logic [GW-1:0]                grant_id
);

    localparam int FRAME_CYCLES = FRAME_BITS * CLKS_PER_BIT;
    localparam int CW           = $clog2(FRAME_CYCLES);

    state_t               state_reg, state_next;
    logic [CW-1:0]        count_reg, count_next;
    logic [WORD_LENGTH-1:0] data_reg, data_next;
    logic [GW-1:0]        grant_reg, grant_next;
    logic [GW-1:0]        last_grant_reg, last_grant_next;
    logic [WORD_LENGTH-1:0] byte_arr [NUM_REQ];
    logic [GW-1:0]        winner;
    logic                 winner_valid;

    // Unpack the flattened source bytes.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
            assign byte_arr[gi] = data_in[gi*WORD_LENGTH +: WORD_LENGTH];
        end
    endgenerate

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req        (req),
        .last_grant (last_grant_reg),
        .winner     (winner),
        .valid      (winner_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: requests only matter in IDLE; WAIT ends as the count reaches 0.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (winner_valid) state_next = ST_LOAD;
            ST_LOAD: state_next = ST_WAIT;
            ST_WAIT: if (count_reg <= CW'(1)) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath next values: capture winner and byte in IDLE, time the frame after.
    always_comb begin
        count_next      = count_reg;
        data_next       = data_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            ST_IDLE: begin
                if (winner_valid) begin
                    data_next       = byte_arr[winner];
                    grant_next      = winner;
                    last_grant_next = winner;
                end
            end
            ST_LOAD: count_next = CW'(FRAME_CYCLES - 1);
            ST_WAIT: if (count_reg != '0) count_next = count_reg - CW'(1);
            default: count_next = '0;
        endcase
    end

    // Datapath registers; last_grant resets to the top index so source 0 goes first.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg      <= '0;
            data_reg       <= '0;
            grant_reg      <= '0;
            last_grant_reg <= GW'(NUM_REQ - 1);
        end else begin
            count_reg      <= count_next;
            data_reg       <= data_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // Outputs: strobe and ack only in LOAD; byte and grant held in registers.
    always_comb begin
        Transmit = 1'b0;
        ack      = '0;
        busy     = (state_reg != ST_IDLE);
        DATATX   = data_reg;
        grant_id = grant_reg;
        if (state_reg == ST_LOAD) begin
            Transmit = 1'b1;
            ack      = NUM_REQ'(1) << grant_reg;
        end
    end

endmodule
